// File: rtl/pin_pkg.sv
// Shared command/response codes and state encodings for the PIN-protected secret store.
package pin_pkg;

  localparam logic [7:0] CMD_SET = 8'h01;
  localparam logic [7:0] CMD_GET = 8'h02;
  localparam logic [7:0] RSP_OK  = 8'h01;
  localparam logic [7:0] RSP_BAD = 8'h00;
  localparam logic [7:0] RSP_ERR = 8'hFF;

  typedef enum logic [1:0] {S_IDLE, S_RX_ARGS, S_EXEC, S_TX_RESP} state_t;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

endpackage

// File: rtl/sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic ext,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta     <= RESET_VAL;
      sync_out <= RESET_VAL;
    end else begin
      meta     <= ext;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/pin_core.sv
// PIN-protected secret store: UART 8N1 receiver, transmitter and command FSM
// with RTS/CTS flow control and a limited wrong-guess budget.
module pin_core
  import pin_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned PIN_BYTES    = 4,
  parameter int unsigned SECRET_BYTES = 4,
  parameter int unsigned MAX_ATTEMPTS = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  input  logic cts,
  output logic tx,
  output logic rts
);

  localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int unsigned PIN_W  = 8 * PIN_BYTES;
  localparam int unsigned SEC_W  = 8 * SECRET_BYTES;
  localparam int unsigned ARG_W  = PIN_W + SEC_W;
  localparam int unsigned RESP_W = SEC_W + 8;
  localparam int unsigned ARGN_W = $clog2(PIN_BYTES + SECRET_BYTES + 1);
  localparam int unsigned RL_W   = $clog2(SECRET_BYTES + 2);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  logic rx_s, cts_s;

  sync #(.RESET_VAL(1'b1)) u_rx_sync  (.clk(clk), .reset(reset), .ext(rx),  .sync_out(rx_s));
  sync #(.RESET_VAL(1'b1)) u_cts_sync (.clk(clk), .reset(reset), .ext(cts), .sync_out(cts_s));

  // UART receiver: mid-bit sampling, glitch abort at the start-bit centre
  rx_state_t        rx_st;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_byte;
  logic             rx_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_st    <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (rx_st)
        RX_IDLE: if (!rx_s) begin
          rx_st  <= RX_START;
          rx_cnt <= '0;
        end
        RX_START: if (rx_cnt == CNT_HALF) begin
          rx_cnt <= '0;
          rx_bit <= '0;
          rx_st  <= rx_s ? RX_IDLE : RX_DATA;
        end else rx_cnt <= rx_cnt + CNT_W'(1);
        RX_DATA: if (rx_cnt == CNT_FULL) begin
          rx_cnt  <= '0;
          rx_byte <= {rx_s, rx_byte[7:1]};
          if (rx_bit == 3'd7) rx_st <= RX_STOP;
          else rx_bit <= rx_bit + 3'd1;
        end else rx_cnt <= rx_cnt + CNT_W'(1);
        RX_STOP: if (rx_cnt == CNT_FULL) begin
          rx_cnt   <= '0;
          rx_valid <= rx_s;
          rx_st    <= rx_s ? RX_IDLE : RX_WAIT_HIGH;
        end else rx_cnt <= rx_cnt + CNT_W'(1);
        RX_WAIT_HIGH: if (rx_s) rx_st <= RX_IDLE;
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

  // UART transmitter: cts gates only the start of a frame
  logic              tx_req, tx_busy, tx_done;
  logic [CNT_W-1:0]  tx_cnt;
  logic [3:0]        tx_left;
  logic [8:0]        tx_sh;
  logic [RESP_W-1:0] resp_buf;
  logic              tx_start_c;

  assign tx_start_c = tx_req && !tx_busy && !cts_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
      tx_cnt  <= '0;
      tx_left <= '0;
      tx_sh   <= '1;
    end else begin
      tx_done <= 1'b0;
      if (!tx_busy) begin
        if (tx_start_c) begin
          tx_busy <= 1'b1;
          tx      <= 1'b0;
          tx_sh   <= {1'b1, resp_buf[RESP_W-1 -: 8]};
          tx_left <= 4'd9;
          tx_cnt  <= '0;
        end
      end else if (tx_cnt == CNT_FULL) begin
        tx_cnt <= '0;
        if (tx_left == 4'd0) begin
          tx_busy <= 1'b0;
          tx_done <= 1'b1;
        end else begin
          tx      <= tx_sh[0];
          tx_sh   <= {1'b1, tx_sh[8:1]};
          tx_left <= tx_left - 4'd1;
        end
      end else tx_cnt <= tx_cnt + CNT_W'(1);
    end
  end

  // Command FSM and secure store
  state_t            state;
  logic [ARG_W-1:0]  arg;
  logic [ARGN_W-1:0] arg_cnt, arg_need;
  logic              is_set;
  logic [PIN_W-1:0]  pin;
  logic [SEC_W-1:0]  secret;
  logic [7:0]        attempts;
  logic [RL_W-1:0]   resp_left;
  logic              pin_match_c;

  // Single full-width compare keeps timing independent of the guessed PIN
  assign pin_match_c = (arg[PIN_W-1:0] == pin);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      rts       <= 1'b1;
      arg       <= '0;
      arg_cnt   <= '0;
      arg_need  <= '0;
      is_set    <= 1'b0;
      pin       <= '0;
      secret    <= '0;
      attempts  <= '0;
      resp_buf  <= '0;
      resp_left <= '0;
      tx_req    <= 1'b0;
    end else begin
      rts <= (state == S_EXEC) || (state == S_TX_RESP);
      case (state)
        S_IDLE: if (rx_valid) begin
          arg_cnt <= '0;
          if (rx_byte == CMD_SET) begin
            is_set   <= 1'b1;
            arg_need <= ARGN_W'(PIN_BYTES + SECRET_BYTES);
            state    <= S_RX_ARGS;
          end else if (rx_byte == CMD_GET) begin
            is_set   <= 1'b0;
            arg_need <= ARGN_W'(PIN_BYTES);
            state    <= S_RX_ARGS;
          end else begin
            resp_buf  <= {RSP_ERR, SEC_W'(0)};
            resp_left <= RL_W'(1);
            tx_req    <= 1'b1;
            state     <= S_TX_RESP;
          end
        end
        S_RX_ARGS: if (rx_valid) begin
          arg <= {arg[ARG_W-9:0], rx_byte};
          if (arg_cnt + ARGN_W'(1) == arg_need) state <= S_EXEC;
          else arg_cnt <= arg_cnt + ARGN_W'(1);
        end
        S_EXEC: begin
          state     <= S_TX_RESP;
          tx_req    <= 1'b1;
          resp_left <= RL_W'(1);
          resp_buf  <= {RSP_BAD, SEC_W'(0)};
          if (is_set) begin
            pin      <= arg[ARG_W-1 -: PIN_W];
            secret   <= arg[SEC_W-1:0];
            attempts <= 8'(MAX_ATTEMPTS);
            resp_buf <= {RSP_OK, SEC_W'(0)};
          end else if (attempts != 8'd0) begin
            if (pin_match_c) begin
              attempts  <= 8'(MAX_ATTEMPTS);
              resp_buf  <= {RSP_OK, secret};
              resp_left <= RL_W'(SECRET_BYTES + 1);
            end else begin
              attempts <= attempts - 8'd1;
            end
          end
        end
        S_TX_RESP: begin
          if (tx_start_c) begin
            tx_req    <= 1'b0;
            resp_buf  <= resp_buf << 8;
            resp_left <= resp_left - RL_W'(1);
          end
          if (tx_done) begin
            if (resp_left == '0) state <= S_IDLE;
            else tx_req <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pin_core.sv
// Self-checking bench for pin_core: directed vector table, corner sequences and
// randomized commands against a behavioural model of the secret store.
module tb_pin_core;

  localparam int unsigned CPB = 4;
  localparam int unsigned MAXA = 3;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [71:0] cmd;
    int unsigned ncmd;
    logic [39:0] rsp;
    int unsigned nrsp;
  } vec_t;

  logic clk = 1'b0, reset = 1'b0, rx = 1'b1, cts = 1'b0;
  logic tx, rts;

  int checks = 0, errors = 0;
  bq_t mon_q;
  logic [31:0] m_pin = '0, m_sec = '0;
  int m_att = 0;

  always #5 clk = ~clk;

  pin_core #(.CLKS_PER_BIT(CPB), .PIN_BYTES(4), .SECRET_BYTES(4), .MAX_ATTEMPTS(MAXA)) dut (
    .clk(clk), .reset(reset), .rx(rx), .cts(cts), .tx(tx), .rts(rts));

  task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string name);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Line monitor: decodes every frame on tx and checks its stop bit
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        chk(32'(tx), 32'd1, "tx_stop_bit");
        mon_q.push_back(b);
      end
    end
  end

  // Reference model of the store: one command in, expected reply out
  function automatic bq_t model_cmd(input bq_t c);
    bq_t r;
    logic [31:0] p;
    if (c[0] == 8'h01) begin
      m_pin = {c[1], c[2], c[3], c[4]};
      m_sec = {c[5], c[6], c[7], c[8]};
      m_att = MAXA;
      r.push_back(8'h01);
    end else if (c[0] == 8'h02) begin
      p = {c[1], c[2], c[3], c[4]};
      if (m_att == 0) r.push_back(8'h00);
      else if (p == m_pin) begin
        m_att = MAXA;
        r.push_back(8'h01);
        for (int i = 3; i >= 0; i--) r.push_back(m_sec[8*i +: 8]);
      end else begin
        m_att = m_att - 1;
        r.push_back(8'h00);
      end
    end else r.push_back(8'hFF);
    return r;
  endfunction

  function automatic bq_t to_q(input logic [71:0] v, input int unsigned n);
    bq_t q;
    for (int i = 0; i < int'(n); i++) q.push_back(v[8*(int'(n)-1-i) +: 8]);
    return q;
  endfunction

  function automatic bq_t mk_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input bit with_b);
    bq_t q;
    q.push_back(op);
    for (int i = 3; i >= 0; i--) q.push_back(a[8*i +: 8]);
    if (with_b) for (int i = 3; i >= 0; i--) q.push_back(b[8*i +: 8]);
    return q;
  endfunction

  task automatic send_raw(input logic [7:0] b, input logic stopbit);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stopbit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_cmd(input bq_t c);
    int t;
    foreach (c[k]) begin
      t = 0;
      while (rts !== 1'b0 && t < 3000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 3000) chk(32'(rts), 32'd0, "rts_wait_timeout");
      send_raw(c[k], 1'b1);
    end
  endtask

  task automatic expect_resp(input bq_t e, input string name);
    int t = 0;
    logic [7:0] got;
    while (mon_q.size() < e.size() && t < 4000) begin
      @(negedge clk);
      t++;
    end
    chk(32'(mon_q.size() >= e.size()), 32'd1, {name, "_reply_timeout"});
    foreach (e[k]) begin
      got = (mon_q.size() > 0) ? mon_q.pop_front() : 8'hxx;
      chk(32'(got), 32'(e[k]), $sformatf("%s_byte%0d", name, k));
    end
    repeat (60) @(negedge clk);
    chk(32'(mon_q.size()), 32'd0, {name, "_extra_bytes"});
    mon_q.delete();
  endtask

  vec_t tbl[17];

  initial begin
    bq_t c, e;
    int r, low_seen, t;

    tbl[0]  = '{72'h02_00000000, 5, 40'h00, 1};
    tbl[1]  = '{72'h01_11223344_AABBCCDD, 9, 40'h01, 1};
    tbl[2]  = '{72'h02_11223344, 5, 40'h01_AABBCCDD, 5};
    tbl[3]  = '{72'h02_00000001, 5, 40'h00, 1};
    tbl[4]  = '{72'h02_00000001, 5, 40'h00, 1};
    tbl[5]  = '{72'h02_00000001, 5, 40'h00, 1};
    tbl[6]  = '{72'h02_11223344, 5, 40'h00, 1};
    tbl[7]  = '{72'h01_11223344_AABBCCDD, 9, 40'h01, 1};
    tbl[8]  = '{72'h02_00000001, 5, 40'h00, 1};
    tbl[9]  = '{72'h02_00000001, 5, 40'h00, 1};
    tbl[10] = '{72'h02_11223344, 5, 40'h01_AABBCCDD, 5};
    tbl[11] = '{72'h02_00000001, 5, 40'h00, 1};
    tbl[12] = '{72'h02_00000001, 5, 40'h00, 1};
    tbl[13] = '{72'h02_00000001, 5, 40'h00, 1};
    tbl[14] = '{72'h02_11223344, 5, 40'h00, 1};
    tbl[15] = '{72'h01_55667788_01020304, 9, 40'h01, 1};
    tbl[16] = '{72'h7E, 1, 40'hFF, 1};

    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk(32'(tx), 32'd1, "reset_tx");
    chk(32'(rts), 32'd1, "reset_rts");
    reset = 1'b0;
    @(posedge clk);
    #1 chk(32'(rts), 32'd0, "rts_after_reset");

    for (int i = 0; i < 17; i++) begin
      c = to_q(tbl[i].cmd, tbl[i].ncmd);
      e = to_q(72'(tbl[i].rsp), tbl[i].nrsp);
      void'(model_cmd(c));
      send_cmd(c);
      expect_resp(e, $sformatf("vec%0d", i));
    end

    // One-cycle low pulse must not be taken as a start bit
    @(negedge clk) rx = 1'b0;
    @(negedge clk) rx = 1'b1;
    repeat (80) @(negedge clk);
    chk(32'(mon_q.size()), 32'd0, "glitch_no_reply");

    // GET byte with a zero stop bit is discarded; store stays in IDLE
    send_raw(8'h02, 1'b0);
    repeat (100) @(negedge clk);
    chk(32'(mon_q.size()), 32'd0, "framing_no_reply");
    c = mk_cmd(8'h02, m_pin, 32'h0, 1'b0);
    e = model_cmd(c);
    send_cmd(c);
    expect_resp(e, "after_framing");

    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 99);
      if (r < 20)      c = mk_cmd(8'h01, $urandom, $urandom, 1'b1);
      else if (r < 65) c = mk_cmd(8'h02, m_pin, 32'h0, 1'b0);
      else if (r < 90) c = mk_cmd(8'h02, $urandom, 32'h0, 1'b0);
      else begin
        c.delete();
        c.push_back(8'($urandom_range(3, 255)));
      end
      e = model_cmd(c);
      send_cmd(c);
      expect_resp(e, $sformatf("rand%0d", k));
    end

    c = mk_cmd(8'h01, 32'hCAFEF00D, 32'h12345678, 1'b1);
    e = model_cmd(c);
    send_cmd(c);
    expect_resp(e, "cts_set");

    // Host not ready: reply must wait on cts
    cts = 1'b1;
    c = mk_cmd(8'h02, 32'hCAFEF00D, 32'h0, 1'b0);
    e = model_cmd(c);
    send_cmd(c);
    low_seen = 0;
    repeat (150) @(negedge clk) if (tx !== 1'b1) low_seen++;
    chk(32'(low_seen), 32'd0, "cts_hold_tx_idle");
    cts = 1'b0;
    expect_resp(e, "cts_release");

    // Reset in the middle of a reply
    c = mk_cmd(8'h02, 32'hCAFEF00D, 32'h0, 1'b0);
    void'(model_cmd(c));
    send_cmd(c);
    t = 0;
    while (tx !== 1'b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk(32'(t < 3000), 32'd1, "reply_start_timeout");
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1 chk(32'(tx), 32'd1, "reset_mid_reply_tx");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_pin = '0;
    m_sec = '0;
    m_att = 0;
    repeat (60) @(negedge clk);
    mon_q.delete();

    c = mk_cmd(8'h02, 32'hCAFEF00D, 32'h0, 1'b0);
    e = model_cmd(c);
    send_cmd(c);
    expect_resp(e, "post_reset_old_pin");
    c = mk_cmd(8'h02, 32'h00000000, 32'h0, 1'b0);
    e = model_cmd(c);
    send_cmd(c);
    expect_resp(e, "post_reset_zero_pin");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
